// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART frame arbiter: FSM state encoding,
// the default frame size and the timer-width helper.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRIG       = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4
  } arb_state_e;

  localparam int DEFAULT_FRAME_BYTES = 18;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One extra bit over the largest count so the saturating timer never wraps.
  function automatic int timer_width(input int gap_cycles, input int start_timeout);
    return $clog2(max_int(gap_cycles, start_timeout)) + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: returns the first set request bit searching upward
// from last+1 and wrapping modulo NREQ. Purely combinational.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest set bit after 'last' wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Shares one UART transmit path among NREQ frame requesters. Grants are
// round-robin; the winning frame is latched into tx_in, the UART is
// triggered, and the next grant waits until the frame has drained plus
// an inter-frame gap. A start timeout guards against a UART that never
// leaves idle.
module uart_frame_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int FRAME_BYTES   = DEFAULT_FRAME_BYTES,
  parameter int GAP_CYCLES    = 1000,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*FRAME_BYTES*8-1:0] frame_in,
  output logic [NREQ-1:0]               ack,
  output logic [NREQ-1:0]               done,
  output logic                          err,
  output logic                          busy,
  output logic [$clog2(NREQ)-1:0]       cur_grant,
  input  logic                          tx_idle,
  output logic                          tx_trigger,
  output logic [FRAME_BYTES*8-1:0]      tx_in
);

  localparam int FW = FRAME_BYTES * 8;
  localparam int IW = $clog2(NREQ);
  localparam int TW = timer_width(GAP_CYCLES, START_TIMEOUT);

  localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
  // A zero gap still spends one cycle in GAP, so both 0 and 1 end at count 0.
  localparam logic [TW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

  arb_state_e      state_q;
  logic [FW-1:0]   tx_in_q;
  logic [FW-1:0]   frame_d;
  logic [IW-1:0]   cur_grant_q;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] done_q;
  logic            err_q;
  logic            busy_q;
  logic            trig_q;
  logic [TW-1:0]   timer_q;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req   (req),
    .last  (cur_grant_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign frame_d = frame_in[int'(pick_idx) * FW +: FW];

  // Arbitration FSM with timer, frame register and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tx_in_q     <= '0;
      cur_grant_q <= IW'(NREQ - 1);
      ack_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      trig_q      <= 1'b0;
      timer_q     <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      trig_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            tx_in_q     <= frame_d;
            cur_grant_q <= pick_idx;
            ack_q       <= NREQ'(1) << pick_idx;
            busy_q      <= 1'b1;
            state_q     <= TRIG;
          end
        end
        TRIG: begin
          trig_q  <= 1'b1;
          timer_q <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (!tx_idle) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TO_LAST) begin
            err_q   <= 1'b1;
            timer_q <= '0;
            state_q <= GAP;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_idle) begin
            done_q  <= NREQ'(1) << cur_grant_q;
            timer_q <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (timer_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign cur_grant  = cur_grant_q;
  assign tx_trigger = trig_q;
  assign tx_in      = tx_in_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: a default build (gap 1000,
// timeout 1024) driven by a small UART responder, plus a zero-gap build
// driven cycle by cycle.
module tb_uart_frame_arbiter;

  localparam int NREQ = 4;
  localparam int FB   = 18;
  localparam int FW   = FB * 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  logic [FW-1:0] f0 = "{hi_i'm_your_army}";
  logic [FW-1:0] f1 = {FB{8'h11}};
  logic [FW-1:0] f2 = {FB{8'h22}};
  logic [FW-1:0] f3 = {FB{8'h33}};
  logic [NREQ*FW-1:0] frameIn;

  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] ack, done;
  logic            err, busy, txTrigger;
  logic            txIdle = 1'b1;
  logic [1:0]      curGrant;
  logic [FW-1:0]   txIn;

  logic [NREQ-1:0] req0 = '0;
  logic [NREQ-1:0] ack0, done0;
  logic            err0, busy0, trig0;
  logic            txIdle0 = 1'b1;
  logic [1:0]      grant0;
  logic [FW-1:0]   txIn0;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  bit uartStuck = 1'b0;
  bit uartKill  = 1'b0;
  bit uartActive = 1'b0;
  int uartCnt = 0;

  assign frameIn = {f3, f2, f1, f0};

  uart_frame_arbiter #(
    .NREQ(NREQ), .FRAME_BYTES(FB), .GAP_CYCLES(1000), .START_TIMEOUT(1024)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .frame_in(frameIn),
    .ack(ack), .done(done), .err(err), .busy(busy), .cur_grant(curGrant),
    .tx_idle(txIdle), .tx_trigger(txTrigger), .tx_in(txIn)
  );

  uart_frame_arbiter #(
    .NREQ(NREQ), .FRAME_BYTES(FB), .GAP_CYCLES(0), .START_TIMEOUT(16)
  ) u_dut_gap0 (
    .clk(clk), .reset_n(reset_n), .req(req0), .frame_in(frameIn),
    .ack(ack0), .done(done0), .err(err0), .busy(busy0), .cur_grant(grant0),
    .tx_idle(txIdle0), .tx_trigger(trig0), .tx_in(txIn0)
  );

  always #5 clk = ~clk;

  // Cycle index used to timestamp observed events.
  always @(posedge clk) cyc <= cyc + 1;

  // UART stand-in: tx_idle falls 3 cycles after a trigger and rises 100 cycles later.
  always @(negedge clk) begin
    if (uartKill) begin
      uartActive = 1'b0;
      txIdle     = 1'b1;
    end else if (uartActive) begin
      uartCnt++;
      if (uartCnt == 3) txIdle = 1'b0;
      if (uartCnt == 103) begin
        txIdle     = 1'b1;
        uartActive = 1'b0;
      end
    end else if (txTrigger && !uartStuck) begin
      uartActive = 1'b1;
      uartCnt    = 0;
    end
  end

  // Hard stop in case a bounded wait is ever defeated.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic doReset();
    @(negedge clk);
    reset_n  = 1'b0;
    uartKill = 1'b1;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    uartKill = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitIdle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 4'b0) begin fails++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (done !== 4'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0000", done); end
    checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (txTrigger !== 1'b0) begin fails++; $display("[TB] FAIL reset_trigger: got %b expected 0", txTrigger); end
    checks++; if (txIn !== '0) begin fails++; $display("[TB] FAIL reset_tx_in: got %h expected 0", txIn); end
    checks++; if (curGrant !== 2'd3) begin fails++; $display("[TB] FAIL reset_cur_grant: got %0d expected 3", curGrant); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL idle_after_release: busy got %b expected 0", busy); end
  endtask

  task automatic test_single_request();
    int n, trigAt, doneAt, idleAt, extraTrig;
    bit sawErr, ok;
    logic [NREQ-1:0] doneVal;
    extraTrig = 0; sawErr = 1'b0; doneAt = -1; idleAt = -1; doneVal = '0;
    @(negedge clk);
    req = 4'b0001;
    n = cyc;
    @(negedge clk);
    checks++; if (ack !== 4'b0001 || cyc != n + 1) begin fails++; $display("[TB] FAIL single_ack: got %b at +%0d expected 0001 at +1", ack, cyc - n); end
    checks++; if (txIn !== f0) begin fails++; $display("[TB] FAIL single_tx_in: got %h expected %h", txIn, f0); end
    checks++; if (txIn[FW-1 -: 8] !== 8'h7b || txIn[7:0] !== 8'h7d) begin fails++; $display("[TB] FAIL single_tx_in_ends: got %h..%h expected 7b..7d", txIn[FW-1 -: 8], txIn[7:0]); end
    checks++; if (curGrant !== 2'd0) begin fails++; $display("[TB] FAIL single_grant: got %0d expected 0", curGrant); end
    checks++; if (busy !== 1'b1 || txTrigger !== 1'b0) begin fails++; $display("[TB] FAIL single_trig_state: busy %b trig %b expected busy 1 trig 0", busy, txTrigger); end
    req = 4'b0000;
    @(negedge clk);
    trigAt = cyc;
    checks++; if (txTrigger !== 1'b1 || ack !== 4'b0) begin fails++; $display("[TB] FAIL single_trigger: trig %b ack %b expected trig 1 ack 0000", txTrigger, ack); end
    @(negedge clk);
    checks++; if (txTrigger !== 1'b0) begin fails++; $display("[TB] FAIL single_trigger_width: got %b expected 0", txTrigger); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txTrigger) extraTrig++;
      if (err) sawErr = 1'b1;
      if (done !== 4'b0) begin
        doneAt = cyc; doneVal = done;
        break;
      end
    end
    // Trigger at T: idle falls at T+3, rises at T+103, done seen at T+104.
    checks++; if (doneAt != trigAt + 104 || doneVal !== 4'b0001) begin fails++; $display("[TB] FAIL single_done: got %b at +%0d expected 0001 at +104", doneVal, doneAt - trigAt); end
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (err) sawErr = 1'b1;
      if (!busy) begin
        idleAt = cyc;
        break;
      end
    end
    checks++; if (idleAt != doneAt + 1000) begin fails++; $display("[TB] FAIL single_busy_fall: got +%0d expected +1000 after done", idleAt - doneAt); end
    checks++; if (extraTrig != 0 || sawErr) begin fails++; $display("[TB] FAIL single_no_extra: extra triggers %0d err %b expected 0 and 0", extraTrig, sawErr); end
    if (idleAt < 0) waitIdle(1200, ok);
  endtask

  task automatic test_all_held();
    int ackCyc [5];
    logic [NREQ-1:0] ackVal [5];
    logic [NREQ-1:0] expOrder [5];
    int nAck, nTrig;
    bit idleSeen;
    expOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    nAck = 0; nTrig = 0; idleSeen = 1'b0;
    doReset();
    req = 4'b1111;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (txTrigger) nTrig++;
      if (ack !== 4'b0 && nAck < 5) begin
        ackCyc[nAck] = cyc;
        ackVal[nAck] = ack;
        nAck++;
        if (nAck == 5) req = 4'b0000;
      end
      if (nAck == 5 && !busy) begin
        idleSeen = 1'b1;
        break;
      end
    end
    req = 4'b0000;
    checks++; if (nAck != 5 || !idleSeen) begin fails++; $display("[TB] FAIL all_ack_count: got %0d acks idle %b expected 5 acks idle 1", nAck, idleSeen); end
    for (int k = 0; k < nAck; k++) begin
      checks++; if (ackVal[k] !== expOrder[k]) begin fails++; $display("[TB] FAIL all_order[%0d]: got %b expected %b", k, ackVal[k], expOrder[k]); end
    end
    // TRIG(1) + WAIT_START(4) + WAIT_DONE(100) + GAP(1000) + IDLE(1) = 1106.
    for (int k = 1; k < nAck; k++) begin
      checks++; if (ackCyc[k] - ackCyc[k-1] != 1106 || ackCyc[k] - ackCyc[k-1] < 1004) begin fails++; $display("[TB] FAIL all_spacing[%0d]: got %0d expected 1106", k, ackCyc[k] - ackCyc[k-1]); end
    end
    checks++; if (nTrig != nAck) begin fails++; $display("[TB] FAIL all_trigger_count: got %0d expected %0d", nTrig, nAck); end
  endtask

  task automatic test_start_timeout();
    int trigAt, errAt;
    bit sawDone, ok, gotDone;
    logic [NREQ-1:0] doneVal;
    sawDone = 1'b0; errAt = -1; gotDone = 1'b0; doneVal = '0;
    uartStuck = 1'b1;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    checks++; if (ack !== 4'b0100) begin fails++; $display("[TB] FAIL timeout_ack: got %b expected 0100", ack); end
    req = 4'b0000;
    @(negedge clk);
    trigAt = cyc;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (done !== 4'b0) sawDone = 1'b1;
      if (err) begin
        errAt = cyc;
        break;
      end
    end
    checks++; if (errAt != trigAt + 1024) begin fails++; $display("[TB] FAIL timeout_err: got +%0d expected +1024", errAt - trigAt); end
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (done !== 4'b0) sawDone = 1'b1;
      if (!busy) break;
    end
    checks++; if (sawDone) begin fails++; $display("[TB] FAIL timeout_no_done: got done pulse expected none"); end
    uartStuck = 1'b0;
    req = 4'b0100;
    @(negedge clk);
    checks++; if (ack !== 4'b0100) begin fails++; $display("[TB] FAIL timeout_next_ack: got %b expected 0100", ack); end
    req = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        gotDone = 1'b1; doneVal = done;
        break;
      end
    end
    checks++; if (!gotDone || doneVal !== 4'b0100) begin fails++; $display("[TB] FAIL timeout_next_done: got %b expected 0100", doneVal); end
    waitIdle(1200, ok);
  endtask

  task automatic test_request_during_wait_done();
    int doneAt, ackAt;
    bit txChanged, earlyAck, ok;
    logic [NREQ-1:0] doneVal, ackVal;
    logic [FW-1:0] txAtAck;
    doneAt = -1; ackAt = -1; txChanged = 1'b0; earlyAck = 1'b0;
    doneVal = '0; ackVal = '0; txAtAck = '0;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    checks++; if (ack !== 4'b0010 || txIn !== f1) begin fails++; $display("[TB] FAIL wd_ack1: got %b expected 0010", ack); end
    req = 4'b0000;
    repeat (11) @(negedge clk);
    req = 4'b0100;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txIn !== f1) txChanged = 1'b1;
      if (ack !== 4'b0) earlyAck = 1'b1;
      if (done !== 4'b0) begin
        doneAt = cyc; doneVal = done;
        break;
      end
    end
    checks++; if (doneVal !== 4'b0010) begin fails++; $display("[TB] FAIL wd_done1: got %b expected 0010", doneVal); end
    checks++; if (txChanged || earlyAck) begin fails++; $display("[TB] FAIL wd_hold: tx changed %b early ack %b expected 0 and 0", txChanged, earlyAck); end
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (ack !== 4'b0) begin
        ackAt = cyc; ackVal = ack; txAtAck = txIn;
        break;
      end
      if (txIn !== f1) txChanged = 1'b1;
    end
    // done in first GAP cycle D, IDLE at D+1000, ack at D+1001.
    checks++; if (ackAt != doneAt + 1001 || ackVal !== 4'b0100) begin fails++; $display("[TB] FAIL wd_ack2: got %b at +%0d expected 0100 at +1001", ackVal, ackAt - doneAt); end
    checks++; if (txAtAck !== f2 || txChanged) begin fails++; $display("[TB] FAIL wd_tx_in2: got %h expected %h", txAtAck, f2); end
    req = 4'b0000;
    waitIdle(1300, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL wd_idle: got busy expected idle"); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok, gotAck;
    logic [NREQ-1:0] ackVal;
    gotAck = 1'b0; ackVal = '0;
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin fails++; $display("[TB] FAIL rst_ack0: got %b expected 0001", ack); end
    req = 4'b0000;
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b1 || txIdle !== 1'b0) begin fails++; $display("[TB] FAIL rst_precondition: busy %b tx_idle %b expected 1 and 0", busy, txIdle); end
    #2;
    reset_n  = 1'b0;
    uartKill = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_async_busy: got %b expected 0", busy); end
    checks++; if (txIn !== '0) begin fails++; $display("[TB] FAIL rst_async_tx_in: got %h expected 0", txIn); end
    checks++; if (curGrant !== 2'd3) begin fails++; $display("[TB] FAIL rst_async_grant: got %0d expected 3", curGrant); end
    checks++; if (ack !== 4'b0 || done !== 4'b0 || err !== 1'b0 || txTrigger !== 1'b0) begin fails++; $display("[TB] FAIL rst_async_pulses: ack %b done %b err %b trig %b expected all 0", ack, done, err, txTrigger); end
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    uartKill = 1'b0;
    req = 4'b1010;
    @(negedge clk);
    checks++; if (ack !== 4'b0010 || curGrant !== 2'd1) begin fails++; $display("[TB] FAIL rst_first_grant: got ack %b grant %0d expected 0010 grant 1", ack, curGrant); end
    req = 4'b1000;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (ack !== 4'b0) begin
        gotAck = 1'b1; ackVal = ack;
        break;
      end
    end
    checks++; if (!gotAck || ackVal !== 4'b1000) begin fails++; $display("[TB] FAIL rst_second_grant: got %b expected 1000", ackVal); end
    req = 4'b0000;
    waitIdle(1300, ok);
  endtask

  task automatic test_gap_zero_back_to_back();
    int ackCyc [3];
    logic [NREQ-1:0] ackVal [3];
    logic [NREQ-1:0] expOrder [3];
    int cnt, nAck;
    bit idleSeen, sawErr;
    expOrder = '{4'b0001, 4'b0010, 4'b0001};
    cnt = -1; nAck = 0; idleSeen = 1'b0; sawErr = 1'b0;
    @(negedge clk);
    req0 = 4'b0011;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err0) sawErr = 1'b1;
      if (ack0 !== 4'b0 && nAck < 3) begin
        ackCyc[nAck] = cyc;
        ackVal[nAck] = ack0;
        nAck++;
        if (nAck == 3) req0 = 4'b0000;
      end
      if (trig0) cnt = 0;
      else if (cnt >= 0) cnt++;
      if (cnt == 2) txIdle0 = 1'b0;
      if (cnt == 7) begin
        txIdle0 = 1'b1;
        cnt = -1;
      end
      if (nAck == 3 && !busy0 && cnt < 0) begin
        idleSeen = 1'b1;
        break;
      end
    end
    req0 = 4'b0000;
    checks++; if (nAck != 3 || !idleSeen || sawErr) begin fails++; $display("[TB] FAIL gap0_count: got %0d acks idle %b err %b expected 3 acks idle 1 err 0", nAck, idleSeen, sawErr); end
    for (int k = 0; k < nAck; k++) begin
      checks++; if (ackVal[k] !== expOrder[k]) begin fails++; $display("[TB] FAIL gap0_order[%0d]: got %b expected %b", k, ackVal[k], expOrder[k]); end
    end
    // 4 fixed cycles + trigger-to-fall 2 + fall-to-rise 5 = 11.
    for (int k = 1; k < nAck; k++) begin
      checks++; if (ackCyc[k] - ackCyc[k-1] != 11) begin fails++; $display("[TB] FAIL gap0_spacing[%0d]: got %0d expected 11", k, ackCyc[k] - ackCyc[k-1]); end
    end
  endtask

  // Scenario sequence; each task leaves the arbiter idle for the next.
  initial begin
    $display("[TB] starting uart_frame_arbiter bench");
    test_reset();
    test_single_request();
    test_all_held();
    test_start_timeout();
    test_request_during_wait_done();
    test_reset_mid_frame();
    test_gap_zero_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
